// File: rtl/sd_wp_poll_master.sv
// Avalon-MM read initiator that polls the SD write-protect PIO bit, debounces it,
// and presents a stable level, a change pulse and a sticky interrupt.
module sd_wp_poll_master #(
    parameter int POLL_DIV       = 1000,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        wp_stable,
    output logic        wp_valid,
    output logic        wp_changed,
    output logic        irq,
    input  logic        irq_ack
);

    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
    localparam logic [2:0]    LAT_LAST   = 3'(READ_LATENCY - 1);
    localparam logic [7:0]    CNT_MAX    = 8'(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    lat_q, lat_d;
    logic [7:0]    cnt_q, cnt_new;
    logic          candidate_q;
    logic          sample_now;
    logic          sample_bit;
    logic          commit;

    // Only bit 0 of the PIO data register carries the write-protect level.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:1];

    assign sample_bit  = avm_readdata[0];
    assign avm_address = 2'b00;
    assign avm_read    = (state_q == REQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lat_d      = lat_q;
        sample_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (!enable) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = REQ;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REQ: begin
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q + 3'd1;
                if (lat_q == LAT_LAST) begin
                    sample_now = 1'b1;
                    lat_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                lat_d   = '0;
            end
        endcase
    end

    // A sample that disagrees with the running candidate restarts the count at 1.
    always_comb begin
        cnt_new = 8'd1;
        if (cnt_q != 8'd0 && sample_bit == candidate_q) begin
            cnt_new = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        end
        commit = sample_now && (cnt_new == CNT_MAX) &&
                 (!wp_valid || sample_bit != wp_stable);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 8'd0;
            candidate_q <= 1'b0;
            wp_stable   <= 1'b0;
            wp_valid    <= 1'b0;
            wp_changed  <= 1'b0;
            irq         <= 1'b0;
        end else begin
            wp_changed <= commit;
            if (sample_now) begin
                cnt_q       <= cnt_new;
                candidate_q <= sample_bit;
            end
            if (commit) begin
                wp_stable <= sample_bit;
                wp_valid  <= 1'b1;
            end
            // The very first commit only establishes a level, it is not a change.
            if (commit && wp_valid) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sd_wp_poll_master.md
Name: sd_wp_poll_master

Overview:
Avalon-MM read initiator that polls the 1-bit SD write-protect input PIO slave (register 0, bit 0, fixed read latency). It periodically issues single-word reads and debounces the returned bit. It presents a stable write-protect level, a change pulse and a sticky interrupt to the SD controller logic. It sits between the PIO slave and the SD card state machine, replacing software polling.

Parameters:
POLL_DIV, 1000, idle cycles between successive polls (>=1)
DEBOUNCE_COUNT, 4, consecutive identical samples required to commit a level (>=1, <=255)
READ_LATENCY, 1, cycles from read-request cycle to valid readdata (>=1, <=7)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  polling enable
avm_address  out  2  slave register address, always 0
avm_read  out  1  read request, one-cycle pulse
avm_readdata  in  32  slave read data; only bit 0 used
wp_stable  out  1  debounced write-protect level (1 = protected, raw polarity of in_port)
wp_valid  out  1  wp_stable has been committed at least once since reset
wp_changed  out  1  one-cycle pulse on every commit
irq  out  1  sticky change interrupt
irq_ack  in  1  clears irq

Behaviour:
- Reset (async, reset_n=0): state IDLE, timer=0, cnt=0, candidate=0. All outputs 0: avm_read, avm_address, wp_stable, wp_valid, wp_changed, irq.
- State machine IDLE -> REQ -> WAIT -> IDLE.
  - IDLE: if enable=1, timer increments each cycle. When timer==POLL_DIV-1, the next state is REQ and timer clears. If enable=0, timer is held at 0 and the block stays in IDLE.
  - REQ: exactly one cycle. avm_read=1, avm_address=0. Next state is WAIT with lat=0.
  - WAIT: lat increments each cycle. On the cycle where lat==READ_LATENCY-1, avm_readdata[0] is sampled at the closing clock edge and the next state is IDLE.
- Poll period is POLL_DIV+1+READ_LATENCY cycles.
- Deasserting enable during REQ/WAIT does not abort the transaction: it completes and its sample is processed.
- avm_read=0 in all states except REQ. avm_readdata is ignored outside the sample cycle.
- Debounce, for each sample s:
  - if cnt!=0 and s==candidate: cnt=min(cnt+1, DEBOUNCE_COUNT)
  - else: candidate=s, cnt=1
- Commit condition: the new cnt==DEBOUNCE_COUNT and (wp_valid==0 or s!=wp_stable).
- On commit (registered, visible the cycle after the sample edge):
  - wp_stable=s, wp_valid=1, wp_changed pulses high for one cycle.
  - irq is set only if wp_valid was already 1. The first commit after reset never raises irq.
- Saturated cnt with an unchanged level produces no further commits or pulses.
- A glitch shorter than DEBOUNCE_COUNT samples restarts cnt at 1 with the new candidate; wp_stable is unaffected.
- irq_ack=1 clears irq on the next edge. If an irq set event and irq_ack occur in the same cycle, set wins (irq stays 1).
- cnt is 8 bits wide; lat is 3 bits wide; timer is $clog2(POLL_DIV) bits wide (minimum 1).

Test Plan:
Common setup for all scenarios: POLL_DIV=4, DEBOUNCE_COUNT=3, READ_LATENCY=1, so the poll period is 6 cycles.
1. Reset release, enable=1, readdata=0 -> first avm_read pulse on the 5th cycle after release (addr=0), repeating every 6 cycles. After the 3rd sample: wp_valid=1, wp_stable=0, one wp_changed pulse, irq=0.
2. After scenario 1, readdata=1 permanently -> wp_stable=1 one cycle after the 3rd sample of value 1. wp_changed pulses once; irq=1 and stays high with no further pulses over 10 polls.
3. Stable 0, then readdata=1 for exactly 2 polls, then 0 -> wp_stable stays 0, no wp_changed pulse, irq stays 0.
4. irq=1 and irq_ack=1 in the same cycle as a new commit's irq set -> irq remains 1. A later isolated irq_ack -> irq=0 next cycle.
5. enable dropped during the REQ cycle -> the WAIT sample is still taken, then no further avm_read while enable=0. Re-enable -> next avm_read after 4 idle cycles.
6. reset_n asserted mid-WAIT -> avm_read, wp_valid, wp_stable and irq go to 0 immediately (asynchronously). After release the sequence restarts exactly as in scenario 1.
